// File: rtl/fifo_status_pkg.sv
// Shared constants and helpers for the FIFO pointer/status controller.
// Optional high-water mark is enabled by defining FIFO_STATUS_PEAK_EN.
package fifo_status_pkg;

    localparam int AF_DEFAULT_C = 12;
    localparam int AE_DEFAULT_C = 2;

    // Bit positions of the status flags inside the packed flag register.
    localparam int FLG_FULL  = 0;
    localparam int FLG_EMPTY = 1;
    localparam int FLG_AF    = 2;
    localparam int FLG_AE    = 3;
    localparam int FLG_OVF   = 4;
    localparam int FLG_UDF   = 5;
    localparam int FLG_NUM   = 6;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned sat_lvl(input int unsigned lvl, input int unsigned max_lvl);
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

endpackage

// File: rtl/fifo_status_ctrl_if.sv
// User-side request/status bundle of the FIFO status controller.
// The peak output (FIFO_STATUS_PEAK_EN) stays a plain port on the top module.
interface fifo_status_ctrl_if
    import fifo_status_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic                       wr;
    logic                       rd;
    logic                       lvl_we;
    logic [ptr_w(ADDR_W)-1:0]   af_in;
    logic [ptr_w(ADDR_W)-1:0]   ae_in;
    logic                       err_clr;
    logic                       wr_en;
    logic                       rd_en;
    logic [ADDR_W-1:0]          waddr;
    logic [ADDR_W-1:0]          raddr;
    logic [ptr_w(ADDR_W)-1:0]   count;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output wr, rd, lvl_we, af_in, ae_in, err_clr,
        input  wr_en, rd_en, waddr, raddr, count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr, rd, lvl_we, af_in, ae_in, err_clr,
        output wr_en, rd_en, waddr, raddr, count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Enable-gated wrapping pointer with synchronous reset; the MSB acts as the wrap bit.
module fifo_wrap_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] ptr
);
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_status_ctrl.sv
// Pointer, fill-count and status-flag controller for a synchronous FIFO.
// Define FIFO_STATUS_PEAK_EN to add the peak high-water mark output.
module fifo_status_ctrl
    import fifo_status_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int AF_DEFAULT = AF_DEFAULT_C,
    parameter int AE_DEFAULT = AE_DEFAULT_C
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_status_ctrl_if.slave        bus
`ifdef FIFO_STATUS_PEAK_EN
    ,
    output logic [ADDR_W:0]          peak
`endif
);
    localparam int PW    = ptr_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_RST  = PW'(sat_lvl(AF_DEFAULT, DEPTH));
    localparam logic [PW-1:0] AE_RST  = PW'(sat_lvl(AE_DEFAULT, DEPTH));
    localparam logic [FLG_NUM-1:0] FLAGS_RST = FLG_NUM'((1 << FLG_EMPTY) | (1 << FLG_AE));

    logic               wr_en;
    logic               rd_en;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [PW-1:0]      count_q, count_d;
    logic [PW-1:0]      af_lvl_q, af_lvl_d;
    logic [PW-1:0]      ae_lvl_q, ae_lvl_d;
    logic [FLG_NUM-1:0] flags_q, flags_d;

    always_comb begin
        wr_en   = bus.wr & ~flags_q[FLG_FULL]  & ~rst;
        rd_en   = bus.rd & ~flags_q[FLG_EMPTY] & ~rst;
        count_d = count_q + PW'(wr_en) - PW'(rd_en);

        af_lvl_d = af_lvl_q;
        ae_lvl_d = ae_lvl_q;
        if (bus.lvl_we) begin
            af_lvl_d = PW'(sat_lvl(32'(bus.af_in), DEPTH));
            ae_lvl_d = PW'(sat_lvl(32'(bus.ae_in), DEPTH));
        end

        // Flags track count_d so they line up with count in the same cycle.
        flags_d            = '0;
        flags_d[FLG_FULL]  = (count_d == DEPTH_C);
        flags_d[FLG_EMPTY] = (count_d == '0);
        flags_d[FLG_AF]    = (count_d >= af_lvl_q);
        flags_d[FLG_AE]    = (count_d <= ae_lvl_q);
        flags_d[FLG_OVF]   = (bus.wr & ~wr_en) | (flags_q[FLG_OVF] & ~bus.err_clr);
        flags_d[FLG_UDF]   = (bus.rd & ~rd_en) | (flags_q[FLG_UDF] & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            af_lvl_q <= AF_RST;
            ae_lvl_q <= AE_RST;
            flags_q  <= FLAGS_RST;
        end else begin
            count_q  <= count_d;
            af_lvl_q <= af_lvl_d;
            ae_lvl_q <= ae_lvl_d;
            flags_q  <= flags_d;
        end
    end

    fifo_wrap_ptr #(.W(PW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .ptr (wptr)
    );

    fifo_wrap_ptr #(.W(PW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .ptr (rptr)
    );

`ifdef FIFO_STATUS_PEAK_EN
    logic [PW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = (count_d > peak_q) ? count_d : peak_q;
        if (bus.err_clr) peak_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign peak = peak_q;
`endif

    assign bus.wr_en        = wr_en;
    assign bus.rd_en        = rd_en;
    assign bus.waddr        = wptr[ADDR_W-1:0];
    assign bus.raddr        = rptr[ADDR_W-1:0];
    assign bus.count        = count_q;
    assign bus.full         = flags_q[FLG_FULL];
    assign bus.empty        = flags_q[FLG_EMPTY];
    assign bus.almost_full  = flags_q[FLG_AF];
    assign bus.almost_empty = flags_q[FLG_AE];
    assign bus.overflow     = flags_q[FLG_OVF];
    assign bus.underflow    = flags_q[FLG_UDF];
endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Directed plus randomized check of fifo_status_ctrl against an occupancy-level model.
// Exercises peak as well when FIFO_STATUS_PEAK_EN is defined.
module tb_fifo_status_ctrl;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int PMOD   = 2 * DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_status_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef FIFO_STATUS_PEAK_EN
    logic [ADDR_W:0] peak;
`endif

    fifo_status_ctrl #(.ADDR_W(ADDR_W), .AF_DEFAULT(12), .AE_DEFAULT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIFO_STATUS_PEAK_EN
        ,
        .peak(peak)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: occupancy and pointers as plain integers.
    int m_count = 0, m_wptr = 0, m_rptr = 0;
    int m_af = 12, m_ae = 2;
    bit m_ovf = 0, m_udf = 0, m_afl = 0, m_ael = 1;
    int m_peak = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit i_wr, input bit i_rd, input bit i_lw, input int i_af,
                        input int i_ae, input bit i_ec, input bit i_rst);
        bit we, re;
        int nc;
        bus.wr      = i_wr;
        bus.rd      = i_rd;
        bus.lvl_we  = i_lw;
        bus.af_in   = 5'(i_af);
        bus.ae_in   = 5'(i_ae);
        bus.err_clr = i_ec;
        rst         = i_rst;
        #2;
        we = i_wr && !i_rst && (m_count != DEPTH);
        re = i_rd && !i_rst && (m_count != 0);
        chk("wr_en", int'(bus.wr_en), int'(we));
        chk("rd_en", int'(bus.rd_en), int'(re));
        if (i_rst) begin
            m_count = 0; m_wptr = 0; m_rptr = 0;
            m_af = 12; m_ae = 2;
            m_ovf = 0; m_udf = 0; m_afl = 0; m_ael = 1;
            m_peak = 0;
        end else begin
            nc    = m_count + int'(we) - int'(re);
            m_ovf = (i_wr && !we) || (m_ovf && !i_ec);
            m_udf = (i_rd && !re) || (m_udf && !i_ec);
            m_afl = (nc >= m_af);
            m_ael = (nc <= m_ae);
            if (i_lw) begin
                m_af = (i_af > DEPTH) ? DEPTH : i_af;
                m_ae = (i_ae > DEPTH) ? DEPTH : i_ae;
            end
            m_peak  = i_ec ? 0 : ((nc > m_peak) ? nc : m_peak);
            m_count = nc;
            m_wptr  = (m_wptr + int'(we)) % PMOD;
            m_rptr  = (m_rptr + int'(re)) % PMOD;
        end
        @(posedge clk);
        #1;
        chk("count",        int'(bus.count),        m_count);
        chk("waddr",        int'(bus.waddr),        m_wptr % DEPTH);
        chk("raddr",        int'(bus.raddr),        m_rptr % DEPTH);
        chk("ptr_diff",     (m_wptr - m_rptr + PMOD) % PMOD, int'(bus.count));
        chk("full",         int'(bus.full),         int'(m_count == DEPTH));
        chk("empty",        int'(bus.empty),        int'(m_count == 0));
        chk("almost_full",  int'(bus.almost_full),  int'(m_afl));
        chk("almost_empty", int'(bus.almost_empty), int'(m_ael));
        chk("overflow",     int'(bus.overflow),     int'(m_ovf));
        chk("underflow",    int'(bus.underflow),    int'(m_udf));
`ifdef FIFO_STATUS_PEAK_EN
        chk("peak",         int'(peak),             m_peak);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bias_w, bias_r;
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1);
        idle(2);

        // Fill to full, then simultaneous wr/rd at full.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Drain to empty and exercise underflow corner cases.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 0);

        // Interleaved traffic wraps both pointers.
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);

        // Saturated almost-full level and zero almost-empty level.
        step(0, 0, 1, 20, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 16, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 12, 2, 1, 0);

        // Reset in the middle of traffic.
        step(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        idle(2);

        // Randomized traffic with shifting write/read bias.
        for (int blk = 0; blk < 20; blk++) begin
            bias_w = $urandom_range(10, 90);
            bias_r = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < bias_w,
                     $urandom_range(0, 99) < bias_r,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 31),
                     $urandom_range(0, 31),
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 199) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_status_ctrl.md
Name: fifo_status_ctrl

Overview:
- Parametrised, fully registered pointer-and-status controller for the synchronous FIFO.
- Owns the write and read pointers and the fill count.
- Gates raw wr/rd requests into accepted memory enables.
- Produces full/empty, programmable almost-full/almost-empty, and sticky overflow/underflow flags.
- Sits between the FIFO user interface and the dual-port storage array; all flags are glitch-free register outputs.

Parameters:
- ADDR_W, 4: storage address width; DEPTH = 2**ADDR_W entries.
- AF_DEFAULT, 12: almost-full level loaded at reset.
- AE_DEFAULT, 2: almost-empty level loaded at reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- rd  in  1  read request.
- lvl_we  in  1  load af_in/ae_in into the level registers.
- af_in  in  ADDR_W+1  new almost-full level.
- ae_in  in  ADDR_W+1  new almost-empty level.
- err_clr  in  1  clear the sticky overflow/underflow flags.
- wr_en  out  1  accepted write (combinational: wr & ~full).
- rd_en  out  1  accepted read (combinational: rd & ~empty).
- waddr  out  ADDR_W  storage write address (wptr[ADDR_W-1:0]).
- raddr  out  ADDR_W  storage read address (rptr[ADDR_W-1:0]).
- count  out  ADDR_W+1  entries held, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1  registered status flags.
- overflow, underflow  out  1  sticky error flags.

Behaviour:
- Pointers: wptr and rptr are ADDR_W+1 bits, with the MSB as the wrap bit. wptr increments on wr_en; rptr increments on rd_en. Both wrap modulo 2**(ADDR_W+1).
- count: registered; next count = count + wr_en - rd_en.
  - Simultaneous wr_en and rd_en leave count unchanged.
  - Debug invariant: count == wptr - rptr (mod 2**(ADDR_W+1)).
- Flag derivation: all flags are computed from the next count and registered, so they agree with count in the same cycle. Zero-cycle lag relative to count; one-cycle latency from request to flag.
  - full = (count_next == DEPTH).
  - empty = (count_next == 0).
  - almost_full = (count_next >= af_lvl).
  - almost_empty = (count_next <= ae_lvl).
- Full boundary: wr while full is rejected (wr_en=0) and sets overflow. wr & rd together while full: read accepted, write rejected, overflow set, count becomes DEPTH-1.
- Empty boundary: rd while empty is rejected (rd_en=0) and sets underflow. wr & rd together while empty: write accepted, read rejected, underflow set, count becomes 1.
- Sticky flags: overflow/underflow stay high until err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- Level registers:
  - lvl_we loads af_lvl/ae_lvl; the new levels affect flags from the next cycle.
  - Levels above DEPTH are saturated to DEPTH on load.
  - af_lvl = 0 forces almost_full high; ae_lvl = DEPTH forces almost_empty high.
- Reset (rst=1 at a clk edge, including mid-traffic):
  - Pointers, count, full, overflow, underflow, almost_full = 0.
  - empty = 1; almost_empty = 1.
  - af_lvl = AF_DEFAULT; ae_lvl = AE_DEFAULT.
  - wr_en and rd_en are held 0 while rst is high.
  - All stored data is logically discarded.

Optional Feature:
- Macro: FIFO_STATUS_PEAK_EN.
- When defined:
  - Adds output port peak (ADDR_W+1 bits), a high-water mark register.
  - peak <= max(peak, count_next) every cycle.
  - peak resets to 0 on rst or on err_clr.
- When undefined: no port and no register; all other behaviour is identical.

Decomposition:
- Shared package fifo_status_pkg holds:
  - Pointer-width function ptr_w(ADDR_W) = ADDR_W+1.
  - Level saturation function.
  - Default AF/AE constants.
  - Flag-index localparams used by the CSR block.
- One natural sub-module: fifo_wrap_ptr (ADDR_W+1-bit enable-gated counter with synchronous reset), instantiated twice for wptr and rptr.

Test Plan (ADDR_W=4, DEPTH=16):
- Reset then idle → count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- 16 consecutive writes → count=16, full=1 on the cycle after the 16th write; almost_full=1 after the 12th write; almost_empty=0 after the 3rd write.
- Full, then wr=rd=1 for one cycle → wr_en=0, rd_en=1, count=15, overflow=1 and held; err_clr pulse → overflow=0 next cycle.
- Empty, then rd=1 → rd_en=0, underflow=1. Empty, then wr=rd=1 → count=1, underflow=1. err_clr together with a new underflow → underflow stays 1.
- 40 writes interleaved with 40 reads (pointer wrap twice) → count always equals wptr-rptr, waddr/raddr wrap 15→0, no spurious full or empty.
- lvl_we with af_in=20, ae_in=0 → af_lvl=16 (saturated), so almost_full only when full and almost_empty only when empty. rst asserted at count=9 → every output returns to its reset value on the next cycle; with FIFO_STATUS_PEAK_EN defined, peak=9 before the reset and 0 after it.
